// File: rtl/npu_output_stage.sv
// NPU output stage: FIFO-buffered fixed-point results, converted at dequeue to int32 or IEEE-754 single.
// Optional macro NPU_OUT_SATURATE_EN clamps int-mode left-shift overflow instead of wrapping.
module npu_output_stage #(
  parameter int DIN_W  = 16,
  parameter int FRAC_W = 7,
  parameter int DEPTH  = 16,
  parameter int OUT_W  = 32
) (
  input  logic                     CLK,
  input  logic                     npu_rst,
  input  logic [DIN_W-1:0]         din,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic [15:0]              cfg_data,
  input  logic                     cfg_we,
  output logic [OUT_W-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef NPU_OUT_SATURATE_EN
  localparam int XW = 64;
  localparam logic signed [XW-1:0] SAT_MAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
  localparam logic signed [XW-1:0] SAT_MIN = -(64'sd1 <<< (OUT_W - 1));
`else
  localparam int XW = OUT_W;
`endif

  generate
    if (OUT_W != 32) begin : g_bad_out_w
      $error("npu_output_stage: OUT_W must be 32");
    end
    if (DIN_W < 8 || DIN_W > 24 || FRAC_W < 0 || FRAC_W >= DIN_W) begin : g_bad_din
      $error("npu_output_stage: DIN_W/FRAC_W out of range");
    end
    if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("npu_output_stage: DEPTH must be a power of two in 4..1024");
    end
  endgenerate

  // Int mode: binary-point shift; the wide intermediate only exists when saturation needs it.
  function automatic logic [OUT_W-1:0] conv_int(input logic [DIN_W-1:0] d, input logic [14:0] s);
    logic signed [XW-1:0] x;
    logic signed [XW-1:0] v;
    x = XW'($signed(d));
    if (s < 15'(FRAC_W)) begin
      v = x >>> (15'(FRAC_W) - s);
    end else if (s <= 15'(FRAC_W + OUT_W - 1)) begin
      v = x <<< (s - 15'(FRAC_W));
    end else begin
      v = '0;
    end
`ifdef NPU_OUT_SATURATE_EN
    if (v > SAT_MAX) begin
      v = SAT_MAX;
    end else if (v < SAT_MIN) begin
      v = SAT_MIN;
    end else begin
      v = v;
    end
`endif
    return v[OUT_W-1:0];
  endfunction

  function automatic logic [31:0] conv_flt(input logic [DIN_W-1:0] d, input logic [7:0] k);
    logic             sgn;
    logic [DIN_W-1:0] mag;
    logic [4:0]       p;
    logic [22:0]      mant;
    logic signed [9:0] e;
    sgn = d[DIN_W-1];
    // Two's-complement negate; the most-negative input yields 2^(DIN_W-1) as an unsigned magnitude.
    mag = sgn ? (~d + DIN_W'(1)) : d;
    p = 5'd0;
    for (int i = 0; i < DIN_W; i++) begin
      if (mag[i]) p = 5'(i);
    end
    mant = 23'(24'(mag) << (5'd23 - p));
    e = 10'(10'd127 + 10'(p) - 10'(FRAC_W) + {{2{k[7]}}, k});
    if (d == '0) begin
      return 32'h0000_0000;
    end else if (e >= 10'sd255) begin
      return {sgn, 8'hFF, 23'd0};
    end else if (e <= 10'sd0) begin
      return {sgn, 31'd0};
    end else begin
      return {sgn, e[7:0], mant};
    end
  endfunction

  logic [DIN_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [LW-1:0]    r_count;
  logic             r_full, r_empty, r_overflow, r_valid;
  logic [15:0]      r_cfg;
  logic [OUT_W-1:0] r_dout;

  logic             w_push, w_load;
  logic [LW-1:0]    w_count_nxt;
  logic [OUT_W-1:0] w_conv;
  logic [DIN_W-1:0] w_head;

  assign w_push = wr_en & ~r_full;
  assign w_load = ~r_empty & (~r_valid | dout_ready);
  assign w_head = r_mem[r_rptr];

  // Next occupancy and converted head word
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_load})
      2'b10:   w_count_nxt = r_count + LW'(1);
      2'b01:   w_count_nxt = r_count - LW'(1);
      default: w_count_nxt = r_count;
    endcase
    if (r_cfg[15]) begin
      w_conv = OUT_W'(conv_flt(w_head, r_cfg[7:0]));
    end else begin
      w_conv = conv_int(w_head, r_cfg[14:0]);
    end
  end

  // Storage array; pointers, not contents, carry the reset
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // Pointers, flags, format register and output register
  always_ff @(posedge CLK) begin
    if (npu_rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_cfg      <= 16'h0000;
      r_dout     <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_load) r_rptr <= r_rptr + AW'(1);
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == LW'(DEPTH));
      r_empty    <= (w_count_nxt == LW'(0));
      r_overflow <= r_overflow | (wr_en & r_full);
      if (cfg_we) r_cfg <= cfg_data;
      if (w_load) begin
        r_dout  <= w_conv;
        r_valid <= 1'b1;
      end else if (dout_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign full       = r_full;
  assign empty      = r_empty;
  assign level      = r_count;
  assign overflow   = r_overflow;
  assign dout       = r_dout;
  assign dout_valid = r_valid;

endmodule

// File: tb/tb_npu_output_stage.sv
// Self-checking bench for npu_output_stage: vector table, hand-written corner sequences, random traffic vs model.
module tb_npu_output_stage;

  localparam int DIN_W  = 16;
  localparam int FRAC_W = 7;
  localparam int DEPTH  = 16;
`ifdef NPU_OUT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        npu_rst, wr_en, cfg_we, dout_ready;
  logic [15:0] din, cfg_data;
  logic        full, empty, overflow, dout_valid;
  logic [4:0]  level;
  logic [31:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  npu_output_stage #(.DIN_W(DIN_W), .FRAC_W(FRAC_W), .DEPTH(DEPTH), .OUT_W(32)) dut (
    .CLK(CLK), .npu_rst(npu_rst), .din(din), .wr_en(wr_en), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .cfg_data(cfg_data), .cfg_we(cfg_we),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: value semantics straight from the number format, not from any shifter structure
  function automatic logic [31:0] ref_conv(input logic [15:0] c, input logic [15:0] d);
    longint x, q, dv;
    int s, k, e;
    real r;
    logic [63:0] b;
    x = longint'($signed(d));
    if (!c[15]) begin
      s = int'(c[14:0]);
      if (s < FRAC_W) begin
        dv = longint'(1) << (FRAC_W - s);
        q = (x >= 0) ? x / dv : -((-x + dv - 1) / dv);
        return 32'(q);
      end else if (s <= FRAC_W + 31) begin
        q = x * (longint'(1) << (s - FRAC_W));
        if (SAT && q > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (SAT && q < -64'sd2147483648) return 32'h8000_0000;
        return 32'(q);
      end else begin
        return 32'h0;
      end
    end
    if (d == 16'h0) return 32'h0;
    k = int'($signed(c[7:0]));
    r = real'(x) * (2.0 ** real'(k - FRAC_W));
    b = $realtobits(r);
    e = int'(b[62:52]) - 1023 + 127;
    if (e >= 255) return {b[63], 8'hFF, 23'h0};
    if (e <= 0) return {b[63], 31'h0};
    return {b[63], 8'(e), b[51:29]};
  endfunction

  typedef struct {
    logic [15:0] cfg;
    logic [15:0] din;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[$];

  // One isolated conversion: load cfg, write one word, wait (bounded) for it and accept it
  task automatic run_vec(input logic [15:0] c, input logic [15:0] d, output logic [31:0] got, output bit ok);
    cfg_data = c; cfg_we = 1'b1; dout_ready = 1'b1;
    tick();
    cfg_we = 1'b0; din = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    ok = 1'b0; got = 32'h0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (dout_valid) begin
        got = dout; ok = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    logic [31:0] got;
    bit ok;
    logic [15:0] fd [18];
    logic [15:0] c, d;
    logic [31:0] exp_q[$];
    int j, sent;

    npu_rst = 1'b1; wr_en = 1'b0; cfg_we = 1'b0; dout_ready = 1'b0;
    din = 16'h0; cfg_data = 16'h0;
    tick(); tick();
    npu_rst = 1'b0;
    tick();
    chk("rst_dout", dout, 32'h0);
    chk("rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_full", {31'h0, full}, 32'h0);
    chk("rst_level", {27'h0, level}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);

    // Latency with reset-default format (int, s=0)
    dout_ready = 1'b1; din = 16'h0380; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("lat_n_valid", {31'h0, dout_valid}, 32'h0);
    chk("lat_n_level", {27'h0, level}, 32'h1);
    chk("lat_n_empty", {31'h0, empty}, 32'h0);
    tick();
    chk("lat_n1_valid", {31'h0, dout_valid}, 32'h1);
    chk("lat_n1_dout", dout, 32'h0000_0007);
    chk("lat_n1_level", {27'h0, level}, 32'h0);
    tick();
    chk("lat_drained", {31'h0, dout_valid}, 32'h0);

    vt.push_back('{16'h0007, 16'h0380, 32'h0000_0380, "int_id_pos"});
    vt.push_back('{16'h0007, 16'hFF80, 32'hFFFF_FF80, "int_id_neg"});
    vt.push_back('{16'h0000, 16'h0380, 32'h0000_0007, "int_s0_pos"});
    vt.push_back('{16'h0000, 16'hFF80, 32'hFFFF_FFFF, "int_s0_neg"});
    vt.push_back('{16'h0002, 16'hFFC1, 32'hFFFF_FFFE, "int_floor"});
    vt.push_back('{16'h8000, 16'h0080, 32'h3F80_0000, "flt_one"});
    vt.push_back('{16'h8000, 16'hFF80, 32'hBF80_0000, "flt_mone"});
    vt.push_back('{16'h8000, 16'h0000, 32'h0000_0000, "flt_zero"});
    vt.push_back('{16'h8001, 16'h0080, 32'h4000_0000, "flt_k1"});
    vt.push_back('{16'h807F, 16'h7FFF, 32'h7F80_0000, "flt_inf"});
    vt.push_back('{16'h80FF, 16'h0080, 32'h3F00_0000, "flt_half"});
    vt.push_back('{16'h8000, 16'h8000, 32'hC380_0000, "flt_minneg"});
    vt.push_back('{16'h8080, 16'h0001, 32'h0000_0000, "flt_uflow"});
    vt.push_back('{16'h8F00, 16'h0080, 32'h3F80_0000, "flt_ignhi"});
    vt.push_back('{16'h0018, 16'h7FFF, SAT ? 32'h7FFF_FFFF : 32'hFFFE_0000, "int_s24_pos"});
    vt.push_back('{16'h0018, 16'h8000, SAT ? 32'h8000_0000 : 32'h0000_0000, "int_s24_neg"});
    vt.push_back('{16'h0026, 16'h0001, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, "int_s38"});
    vt.push_back('{16'h0027, 16'h7FFF, 32'h0000_0000, "int_s39"});

    foreach (vt[i]) begin
      run_vec(vt[i].cfg, vt[i].din, got, ok);
      chk({vt[i].name, "_seen"}, {31'h0, ok}, 32'h1);
      chk(vt[i].name, got, vt[i].exp);
    end

    // Fill past capacity with the consumer stalled
    cfg_data = 16'h0007; cfg_we = 1'b1; dout_ready = 1'b0;
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 18; i++) begin
      fd[i] = 16'($urandom);
      din = fd[i]; wr_en = 1'b1;
      tick();
      if (i == 16) begin
        chk("fill_full", {31'h0, full}, 32'h1);
        chk("fill_level", {27'h0, level}, 32'd16);
        chk("fill_noovf", {31'h0, overflow}, 32'h0);
      end
    end
    wr_en = 1'b0;
    chk("ovf_set", {31'h0, overflow}, 32'h1);
    chk("ovf_level", {27'h0, level}, 32'd16);
    chk("held_dout", dout, ref_conv(16'h0007, fd[0]));
    tick();
    chk("hold_valid", {31'h0, dout_valid}, 32'h1);
    chk("hold_dout", dout, ref_conv(16'h0007, fd[0]));

    // Drain with a format change on the first accepting edge
    cfg_data = 16'h0000; cfg_we = 1'b1; dout_ready = 1'b1;
    j = 0;
    for (int cyc = 0; cyc < 60 && j < 17; cyc++) begin
      if (dout_valid) begin
        chk($sformatf("drain_%0d", j), dout, ref_conv((j < 2) ? 16'h0007 : 16'h0000, fd[j]));
        j++;
      end
      tick();
      cfg_we = 1'b0;
    end
    chk("drain_count", 32'(j), 32'd17);
    chk("drain_empty", {31'h0, empty}, 32'h1);
    chk("drain_valid", {31'h0, dout_valid}, 32'h0);
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);

    // Reset while words are queued and one is held
    cfg_data = 16'h8000; cfg_we = 1'b1; dout_ready = 1'b0;
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 16'(16'h0100 + i); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    npu_rst = 1'b1;
    tick();
    npu_rst = 1'b0;
    chk("mrst_valid", {31'h0, dout_valid}, 32'h0);
    chk("mrst_empty", {31'h0, empty}, 32'h1);
    chk("mrst_level", {27'h0, level}, 32'h0);
    chk("mrst_ovf", {31'h0, overflow}, 32'h0);
    chk("mrst_dout", dout, 32'h0);
    dout_ready = 1'b1; din = 16'h0380; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    chk("mrst_cfg_default", dout, 32'h0000_0007);
    tick();

    // Random traffic per format, random back-pressure, checked against the reference queue
    for (int round = 0; round < 8; round++) begin
      if ($urandom_range(0, 1) == 0) c = {1'b0, 15'($urandom_range(0, 40))};
      else c = {1'b1, 15'($urandom)};
      cfg_data = c; cfg_we = 1'b1; dout_ready = 1'b0;
      tick();
      cfg_we = 1'b0;
      sent = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 300 && (sent < 12 || exp_q.size() > 0 || dout_valid); cyc++) begin
        dout_ready = 1'($urandom_range(0, 1));
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) chk("rnd_spurious", dout, 32'hDEAD_BEEF);
          else chk($sformatf("rnd_r%0d_cfg%04h", round, c), dout, exp_q.pop_front());
        end
        wr_en = 1'b0;
        if (sent < 12 && $urandom_range(0, 1) == 1) begin
          d = 16'($urandom);
          case ($urandom_range(0, 7))
            0:       d = 16'h8000;
            1:       d = 16'h0000;
            default: d = d;
          endcase
          din = d; wr_en = 1'b1;
          exp_q.push_back(ref_conv(c, d));
          sent++;
        end
        tick();
      end
      wr_en = 1'b0;
      chk($sformatf("rnd_r%0d_left", round), 32'(exp_q.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
